x_multdiv_unit: RTL and testbench
=================================

// Module: x_multdiv_unit
// PURPOSE
//  Execute-stage multi-cycle multiply/divide unit. Fed directly by the D/X pipeline latch outputs (ir, a, b).
//  Decodes mul/div, runs a 32-iteration signed operation and stalls fetch, F/D and D/X until the result is ready.
//  Presents the result for one cycle to the X-stage result mux ahead of the X/M latch.
//  Non-mul/div instructions pass untouched; ALU handles them.
// PARAMETERS
//  RTYPE_OP   5'b00000  opcode ir[31:27] of R-type instructions
//  MUL_ALUOP  5'b00110  ALU op ir[6:2] selecting signed multiply
//  DIV_ALUOP  5'b00111  ALU op ir[6:2] selecting signed divide
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low reset
//  ir_in          in   32  instruction from D/X latch ir_out
//  a_in           in   32  operand A (rs) from D/X latch a_out
//  b_in           in   32  operand B (rt) from D/X latch b_out
//  flush          in   1   branch/jump squash of the X-stage instruction
//  stall          out  1   hold PC, F/D, D/X; insert nop into X/M
//  result_valid   out  1   one-cycle pulse: result_out/result_rd/exception valid
//  result_out     out  32  low 32 bits of product, or quotient
//  result_rd      out  5   destination ir[26:22] captured at start
//  exception      out  1   overflow / divide-by-zero flag, qualified by result_valid
//  op_is_div      out  1   1 = completed op was div (rstatus 5), 0 = mul (rstatus 4)
// BEHAVIOUR
//  Reset (reset=0, any time, async):
//   state=IDLE, count=0; stall=0, result_valid=0, result_out=0, result_rd=0, exception=0, op_is_div=0.
//   An in-flight op is discarded.
//  is_md = (ir_in[31:27]==RTYPE_OP) && (ir_in[6:2]==MUL_ALUOP || ir_in[6:2]==DIV_ALUOP).
//  States:
//   IDLE
//    - stall = is_md & ~flush.
//    - On edge with is_md & ~flush: capture a_in, b_in, ir_in[26:22], op; count=0; go RUN.
//   RUN
//    - stall=1; one iteration per cycle; count increments.
//    - On edge with count==31: go DONE.
//   DONE
//    - stall=0; result_valid = ~flush; outputs driven from registers.
//    - Unconditionally go IDLE; the mul/div still visible on ir_in this cycle does NOT restart.
//  Latency: issue cycle 0 (IDLE) + 32 RUN cycles = stall high 33 cycles; result_valid in cycle 33.
//  Back-to-back: the next mul/div reaches ir_in the cycle after DONE and starts from IDLE normally.
//  flush:
//   - In RUN: abort to IDLE next edge, stall drops the following cycle, no result_valid.
//   - In DONE: result_valid suppressed.
//  Mul: signed 32x32 -> 64; result_out = p[31:0]; exception=1 iff p[63:32] != {32{p[31]}}.
//  Div: signed, quotient truncated toward zero, remainder discarded.
//   - b==0: result_out=0, exception=1.
//   - a==0x80000000 & b==0xFFFFFFFF: result_out=0x80000000, exception=1.
//   - Otherwise exception=0.
//  result_out/result_rd/exception/op_is_div hold their last values outside DONE; consumers qualify with result_valid.
//  rd==0 is computed and reported normally; writeback discards it.
// TESTING
//  1. mul a=7 b=0xFFFFFFFA -> stall high 33 cycles, 1-cycle result_valid, result_out=0xFFFFFFD6, exception=0, op_is_div=0.
//  2. mul a=0x00010000 b=0x00010000 -> result_out=0x00000000, exception=1;
//     mul 0x7FFFFFFF*2 -> 0xFFFFFFFE, exception=1.
//  3. div -7/2 -> 0xFFFFFFFD, exc=0; div 5/0 -> 0, exc=1; div 0x80000000/-1 -> 0x80000000, exc=1; op_is_div=1.
//  4. flush=1 in RUN cycle 10 -> IDLE, stall=0 from cycle 12, no result_valid.
//     flush with mul in IDLE -> stall=0, no start.
//  5. reset=0 asynchronously in RUN cycle 20 -> all outputs 0 before next edge.
//     After release with add on ir_in: stall=0.
//  6. mul (rd=3) then div (rd=4) back-to-back -> two valid pulses 34 cycles apart, rd 3 then 4;
//     random non-md ir_in never raises stall.

Source files
------------

// File: rtl/x_multdiv_unit.sv
// x_multdiv_unit
// Execute-stage multi-cycle signed multiply/divide unit. It sits beside the
// ALU, watches the D/X latch outputs and, on a mul/div, stalls the front of the
// pipeline. It then runs 32 shift/add or shift/subtract iterations on operand
// magnitudes and presents the result for one cycle to the X-stage result mux.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   ir_in         instruction from the D/X latch
//   a_in, b_in    operands rs / rt from the D/X latch
//   flush         squash of the X-stage instruction (branch/jump)
//   stall         hold PC, F/D and D/X; insert a nop into X/M
//   result_valid  one-cycle pulse qualifying result_out/result_rd/exception
//   result_out    low 32 bits of the product, or the quotient
//   result_rd     destination register of the completed op
//   exception     overflow / divide-by-zero flag of the completed op
//   op_is_div     1 = completed op was div, 0 = mul
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a mul/div on ir_in; stalls combinationally on one
// S_RUN  | one iteration per cycle, count 0..31
// S_DONE | result registers valid; pulse result_valid unless flushed
module x_multdiv_unit #(
  parameter logic [4:0] RTYPE_OP  = 5'b00000,
  parameter logic [4:0] MUL_ALUOP = 5'b00110,
  parameter logic [4:0] DIV_ALUOP = 5'b00111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result_out,
  output logic [4:0]  result_rd,
  output logic        exception,
  output logic        op_is_div
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  // mul: {partial product high, multiplier shifting out at bit 0}
  // div: {partial remainder, dividend shifting out at bit 31 / quotient in at bit 0}
  logic [63:0] work;
  logic [31:0] mag_b;
  logic        neg;
  logic        is_div;
  logic        b_zero;
  logic        div_ovf;
  logic [4:0]  rd_q;

  logic        is_md;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] work_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] fin_res;
  logic        fin_exc;

  // Register-field bits the unit never looks at; reduced here so lint sees them consumed.
  logic unused_ir;
  assign unused_ir = ^{ir_in[21:7], ir_in[1:0]};

  assign is_md = (ir_in[31:27] == RTYPE_OP) &&
                 ((ir_in[6:2] == MUL_ALUOP) || (ir_in[6:2] == DIV_ALUOP));
  assign start = is_md && !flush;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  assign a_mag = a_in[31] ? (32'd0 - a_in) : a_in;
  assign b_mag = b_in[31] ? (32'd0 - b_in) : b_in;

  always_comb begin
    mul_sum = {1'b0, work[63:32]} + (work[0] ? {1'b0, mag_b} : 33'd0);
    div_sh  = {work[63:32], work[31]};
    // Remainder stays below the divisor, so a set bit 32 always means "fits";
    // the 32-bit wraparound subtract is then still exact.
    div_ge  = div_sh[32] || (div_sh[31:0] >= mag_b);
    div_sub = div_sh[31:0] - mag_b;
    if (is_div)
      work_nxt = {(div_ge ? div_sub : div_sh[31:0]), work[30:0], div_ge};
    else
      work_nxt = {mul_sum, work[31:1]};
  end

  // Final sign fix-up and flags, taken from the last iteration's result.
  always_comb begin
    prod = neg ? (64'd0 - work_nxt) : work_nxt;
    quo  = neg ? (32'd0 - work_nxt[31:0]) : work_nxt[31:0];
    if (is_div) begin
      fin_res = b_zero ? 32'd0 : quo;
      fin_exc = b_zero || div_ovf;
    end else begin
      fin_res = prod[31:0];
      fin_exc = (prod[63:32] != {32{prod[31]}});
    end
  end

  // Gated by reset so nothing is stalled while the unit is held in reset.
  assign stall        = reset && (((state == S_IDLE) && start) || (state == S_RUN));
  assign result_valid = (state == S_DONE) && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= 5'd0;
      work       <= 64'd0;
      mag_b      <= 32'd0;
      neg        <= 1'b0;
      is_div     <= 1'b0;
      b_zero     <= 1'b0;
      div_ovf    <= 1'b0;
      rd_q       <= 5'd0;
      result_out <= 32'd0;
      result_rd  <= 5'd0;
      exception  <= 1'b0;
      op_is_div  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work    <= {32'd0, a_mag};
            mag_b   <= b_mag;
            neg     <= a_in[31] ^ b_in[31];
            is_div  <= (ir_in[6:2] == DIV_ALUOP);
            b_zero  <= (b_in == 32'd0);
            div_ovf <= (a_in == 32'h8000_0000) && (b_in == 32'hFFFF_FFFF);
            rd_q    <= ir_in[26:22];
            count   <= 5'd0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            count <= 5'd0;
            state <= S_IDLE;
          end else begin
            work  <= work_nxt;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              result_out <= fin_res;
              exception  <= fin_exc;
              op_is_div  <= is_div;
              result_rd  <= rd_q;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The finished mul/div is still on ir_in this cycle; never restart here.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_multdiv_unit.sv
module tb_x_multdiv_unit;

  localparam logic [4:0] MUL_OP = 5'b00110;
  localparam logic [4:0] DIV_OP = 5'b00111;
  localparam logic [31:0] ADD_IR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir_in = 32'd0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        result_valid;
  logic [31:0] result_out;
  logic [4:0]  result_rd;
  logic        exception;
  logic        op_is_div;

  int errors = 0;
  int checks = 0;

  x_multdiv_unit dut (
    .clock(clock), .reset(reset), .ir_in(ir_in), .a_in(a_in), .b_in(b_in),
    .flush(flush), .stall(stall), .result_valid(result_valid),
    .result_out(result_out), .result_rd(result_rd), .exception(exception),
    .op_is_div(op_is_div)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_ir(input logic [4:0] rd, input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'd0;
    r[26:22] = rd;
    r[6:2]   = op;
    return r;
  endfunction

  // Reference: plain signed arithmetic on the operands.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q; e = 1'b0;
    end
  endfunction

  // Issues one op, holds it on ir_in until the result pulse, then drives adds.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        output int stall_cnt, output int valid_cyc, output int valid_cnt,
                        output logic [31:0] res, output logic [4:0] rd,
                        output logic exc, output logic isd);
    stall_cnt = 0; valid_cyc = -1; valid_cnt = 0;
    res = 'x; rd = 'x; exc = 1'bx; isd = 1'bx;
    @(posedge clock); #1;
    ir_in = ir; a_in = a; b_in = b; flush = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (stall) stall_cnt++;
      if (result_valid) begin
        valid_cnt++; valid_cyc = i;
        res = result_out; rd = result_rd; exc = exception; isd = op_is_div;
      end
      @(posedge clock); #1;
      if (valid_cnt > 0) begin
        ir_in = ADD_IR; a_in = $urandom; b_in = $urandom;
      end
    end
  endtask

  task automatic check_op(input string name, input bit is_div, input logic [4:0] rdx,
                          input logic [31:0] a, input logic [31:0] b, input bit timing);
    int sc, vc, vn;
    logic [31:0] res, er;
    logic [4:0] rd;
    logic exc, isd, ee;
    model(is_div, a, b, er, ee);
    run_op(mk_ir(rdx, is_div ? DIV_OP : MUL_OP), a, b, sc, vc, vn, res, rd, exc, isd);
    checks++;
    if (vn !== 1) begin
      errors++; $display("FAIL %s valid_pulses got=%0d exp=1", name, vn);
    end
    checks++;
    if (res !== er || exc !== ee || isd !== is_div || rd !== rdx) begin
      errors++;
      $display("FAIL %s a=%h b=%h got res=%h exc=%b div=%b rd=%0d exp res=%h exc=%b div=%b rd=%0d",
               name, a, b, res, exc, isd, rd, er, ee, is_div, rdx);
    end
    if (timing) begin
      checks++;
      if (sc !== 33 || vc !== 33) begin
        errors++; $display("FAIL %s timing got stall=%0d valid_cyc=%0d exp 33/33", name, sc, vc);
      end
    end
  endtask

  task automatic test_reset();
    ir_in = mk_ir(5'd1, MUL_OP); a_in = 32'd3; b_in = 32'd4;
    #12;
    checks++;
    if ({stall, result_valid, result_out, result_rd, exception, op_is_div} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b v=%b res=%h rd=%0d exc=%b div=%b exp all 0",
               stall, result_valid, result_out, result_rd, exception, op_is_div);
    end
    ir_in = ADD_IR;
    @(negedge clock); #2 reset = 1'b1;
  endtask

  task automatic test_mul();
    check_op("mul_7_x_neg6", 1'b0, 5'd5, 32'd7, 32'hFFFF_FFFA, 1'b1);
    check_op("mul_2p16_sq", 1'b0, 5'd6, 32'h0001_0000, 32'h0001_0000, 1'b1);
    check_op("mul_max_x2", 1'b0, 5'd7, 32'h7FFF_FFFF, 32'd2, 1'b0);
    check_op("mul_min_x1", 1'b0, 5'd8, 32'h8000_0000, 32'd1, 1'b0);
    check_op("mul_min_xm1", 1'b0, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 2 == 0) begin a = $signed(a) >>> 16; b = $signed(b) >>> 17; end
      check_op("mul_rand", 1'b0, 5'($urandom), a, b, 1'b0);
    end
  endtask

  task automatic test_div();
    check_op("div_m7_2", 1'b1, 5'd10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_op("div_5_0", 1'b1, 5'd11, 32'd5, 32'd0, 1'b0);
    check_op("div_7_m2", 1'b1, 5'd0, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check_op("div_big_small", 1'b1, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 3 == 0) b = $signed(b) >>> 20;
      if (i == 4) b = 32'd0;
      check_op("div_rand", 1'b1, 5'($urandom), a, b, 1'b0);
    end
    check_op("div_min_m1", 1'b1, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_flush();
    int bad = 0;
    int vn = 0;
    logic st10 = 1'b0;
    @(posedge clock); #1;
    ir_in = mk_ir(5'd2, MUL_OP); a_in = 32'd9; b_in = 32'd9; flush = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 10) flush = 1'b1;
      if (i == 11) begin flush = 1'b0; ir_in = ADD_IR; end
      @(negedge clock);
      if (i == 10) st10 = stall;
      if (i >= 12 && stall) bad++;
      if (result_valid) vn++;
      @(posedge clock); #1;
    end
    checks++;
    if (st10 !== 1'b1) begin
      errors++; $display("FAIL flush_run_stall_c10 got=%b exp=1", st10);
    end
    checks++;
    if (bad !== 0 || vn !== 0) begin
      errors++; $display("FAIL flush_run_abort got stall_cycles=%0d valids=%0d exp 0/0", bad, vn);
    end
    ir_in = mk_ir(5'd2, MUL_OP); flush = 1'b1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall got=%b exp=0", stall);
    end
    @(posedge clock); #1;
    flush = 1'b0; ir_in = ADD_IR;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle_nostart got=%b exp=0", stall);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    @(posedge clock); #1;
    ir_in = mk_ir(5'd4, MUL_OP); a_in = 32'd123; b_in = 32'd456;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({stall, result_valid, result_out, result_rd, exception, op_is_div} !== 40'd0) begin
      errors++;
      $display("FAIL async_reset got stall=%b v=%b res=%h rd=%0d exc=%b div=%b exp all 0",
               stall, result_valid, result_out, result_rd, exception, op_is_div);
    end
    ir_in = ADD_IR;
    #3 reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall || result_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL after_reset_add got busy_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int vcyc[$];
    logic [4:0] vrd[$];
    logic [31:0] vres[$];
    logic [31:0] e1, e2;
    logic x1, x2;
    bit switched = 0;
    model(1'b0, 32'd1000, 32'hFFFF_FFFD, e1, x1);
    model(1'b1, 32'd1000, 32'd7, e2, x2);
    @(posedge clock); #1;
    ir_in = mk_ir(5'd3, MUL_OP); a_in = 32'd1000; b_in = 32'hFFFF_FFFD;
    for (int i = 0; i < 90; i++) begin
      @(negedge clock);
      if (result_valid) begin
        vcyc.push_back(i); vrd.push_back(result_rd); vres.push_back(result_out);
      end
      @(posedge clock); #1;
      if (vcyc.size() == 1 && !switched) begin
        switched = 1; ir_in = mk_ir(5'd4, DIV_OP); a_in = 32'd1000; b_in = 32'd7;
      end else if (vcyc.size() == 2) begin
        ir_in = ADD_IR;
      end
    end
    checks++;
    if (vcyc.size() != 2) begin
      errors++; $display("FAIL b2b_pulses got=%0d exp=2", vcyc.size());
    end else begin
      checks++;
      if (vcyc[1] - vcyc[0] != 34 || vrd[0] !== 5'd3 || vrd[1] !== 5'd4) begin
        errors++;
        $display("FAIL b2b_order got gap=%0d rd=%0d,%0d exp gap=34 rd=3,4",
                 vcyc[1] - vcyc[0], vrd[0], vrd[1]);
      end
      checks++;
      if (vres[0] !== e1 || vres[1] !== e2) begin
        errors++; $display("FAIL b2b_values got %h,%h exp %h,%h", vres[0], vres[1], e1, e2);
      end
    end
  endtask

  task automatic test_non_md();
    int hits = 0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] r;
      @(posedge clock); #1;
      r = $urandom;
      if (i % 2 == 0) r[31:27] = 5'd0;
      if (r[31:27] == 5'd0 && (r[6:2] == MUL_OP || r[6:2] == DIV_OP)) r[6] = 1'b1;
      ir_in = r; a_in = $urandom; b_in = $urandom; flush = 1'($urandom);
      @(negedge clock);
      if (stall || result_valid) hits++;
    end
    flush = 1'b0; ir_in = ADD_IR;
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL non_md_stall got busy_cycles=%0d exp=0", hits);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_non_md();
    check_op("mul_after_all", 1'b0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
